program_fetch_controller: RTL and testbench

- Sequencer for the combinational, word-indexed program memory: owns the program counter, drives the memory byte address, and registers each fetched instruction into a one-entry output slot with a valid/ready handshake toward decode.
- Handles start/halt, branch/jump redirect with flush, consumer backpressure, and sticky fault detection for misaligned or out-of-range fetches.

---
 rtl/program_fetch_controller.sv | 75 +++++++
 tb/tb_program_fetch_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/program_fetch_controller.sv
// program_fetch_controller: PC sequencer for a word-indexed program memory with a one-entry valid/ready output slot and sticky fetch faults.
module program_fetch_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic                  Halt,
  input  logic                  Redirect,
  input  logic [DATA_WIDTH-1:0] RedirectTarget,
  input  logic [DATA_WIDTH-1:0] MemInstruction,
  input  logic                  InstrReady,
  output logic [DATA_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic [DATA_WIDTH-1:0] InstrPC,
  output logic                  InstrValid,
  output logic                  Fault,
  output logic [DATA_WIDTH-1:0] FaultPC,
  output logic [1:0]            State
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN = 2'b01;
  localparam logic [1:0] FAULT = 2'b10;
  localparam logic [DATA_WIDTH-1:0] WINDOW = DATA_WIDTH'(MEMORY_DEPTH * 4);
  logic [DATA_WIDTH-1:0] pc;
  logic slot_free, handshake, legal;
  assign MemAddress = pc - TEXT_BASE;
  assign slot_free = !InstrValid || InstrReady;
  assign handshake = InstrValid && InstrReady;
  // The offset compare alone would accept a PC below TEXT_BASE once the subtraction wraps.
  assign legal = (pc[1:0] == 2'b00) && (pc >= TEXT_BASE) && (MemAddress < WINDOW);
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
      Instruction <= '0;
      InstrPC <= '0;
      InstrValid <= 1'b0;
      Fault <= 1'b0;
      FaultPC <= '0;
      State <= IDLE;
    end else begin
      case (State)
        IDLE: begin
          if (handshake) InstrValid <= 1'b0;
          if (Redirect) pc <= RedirectTarget;
          if (Start) State <= RUN;
        end
        RUN: begin
          if (Redirect) begin
            pc <= RedirectTarget;
            InstrValid <= 1'b0;
            if (Halt) State <= IDLE;
          end else if (Halt) begin
            if (handshake) InstrValid <= 1'b0;
            State <= IDLE;
          end else if (slot_free && legal) begin
            Instruction <= MemInstruction;
            InstrPC <= pc;
            InstrValid <= 1'b1;
            pc <= pc + DATA_WIDTH'(4);
          end else if (slot_free) begin
            Fault <= 1'b1;
            FaultPC <= pc;
            InstrValid <= 1'b0;
            State <= FAULT;
          end
        end
        default: InstrValid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_program_fetch_controller.sv
// tb_program_fetch_controller: directed checks of fetch, backpressure, redirect, fault, halt and reset behaviour.
module tb_program_fetch_controller;
  logic clk = 1'b0, reset = 1'b0, Start = 1'b0, Halt = 1'b0, Redirect = 1'b0, InstrReady = 1'b0;
  logic [31:0] RedirectTarget = '0, MemInstruction, MemAddress, Instruction, InstrPC, FaultPC;
  logic InstrValid, Fault;
  logic [1:0] State;
  logic [31:0] rom [0:31];
  int n_chk = 0, n_fail = 0, n_valid;
  logic [31:0] last_pc;

  program_fetch_controller dut (
    .clk(clk), .reset(reset), .Start(Start), .Halt(Halt), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .MemInstruction(MemInstruction), .InstrReady(InstrReady),
    .MemAddress(MemAddress), .Instruction(Instruction), .InstrPC(InstrPC),
    .InstrValid(InstrValid), .Fault(Fault), .FaultPC(FaultPC), .State(State)
  );

  always #5 clk = ~clk;
  assign MemInstruction = rom[MemAddress[6:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(State), 32'd0);
    chk({tag, "_valid"}, 32'(InstrValid), 32'd0);
    chk({tag, "_fault"}, 32'(Fault), 32'd0);
    chk({tag, "_faultpc"}, FaultPC, 32'h0);
    chk({tag, "_instr"}, Instruction, 32'h0);
    chk({tag, "_instrpc"}, InstrPC, 32'h0);
    chk({tag, "_addr"}, MemAddress, 32'h0);
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, 32'(InstrValid), 32'(v));
    chk({tag, "_pc"}, InstrPC, pc);
    chk({tag, "_instr"}, Instruction, ins);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0007;
    rom[2] = 32'h0109_5020;
    rom[3] = 32'h2149_FFFF;
    step(); step();
    chk_reset("reset");
    // start, first capture one edge after RUN entry
    reset = 1'b1; InstrReady = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("run_state", 32'(State), 32'd1);
    chk("run_novalid", 32'(InstrValid), 32'd0);
    step();
    chk_slot("f0", 1'b1, 32'h0040_0000, 32'h2008_0005);
    chk("f0_addr", MemAddress, 32'h4);
    // backpressure
    InstrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_slot("bp", 1'b1, 32'h0040_0000, 32'h2008_0005);
      chk("bp_addr", MemAddress, 32'h4);
    end
    InstrReady = 1'b1;
    step();
    chk_slot("f1", 1'b1, 32'h0040_0004, 32'h2009_0007);
    chk("f1_addr", MemAddress, 32'h8);
    step();
    chk_slot("f2", 1'b1, 32'h0040_0008, 32'h0109_5020);
    chk("f2_addr", MemAddress, 32'hC);
    step();
    chk_slot("f3", 1'b1, 32'h0040_000C, 32'h2149_FFFF);
    chk("f3_addr", MemAddress, 32'h10);
    // redirect flushes an unconsumed instruction
    InstrReady = 1'b0; Redirect = 1'b1; RedirectTarget = 32'h0040_0010;
    step();
    Redirect = 1'b0;
    chk("rd_flush", 32'(InstrValid), 32'd0);
    chk("rd_addr", MemAddress, 32'h10);
    step();
    chk_slot("rd_tgt", 1'b1, 32'h0040_0010, 32'hA000_0004);
    // misaligned redirect faults at its capture
    InstrReady = 1'b1; Redirect = 1'b1; RedirectTarget = 32'h0040_0006;
    step();
    Redirect = 1'b0;
    chk("mis_flush", 32'(InstrValid), 32'd0);
    chk("mis_state", 32'(State), 32'd1);
    step();
    chk("mis_fault", 32'(Fault), 32'd1);
    chk("mis_faultpc", FaultPC, 32'h0040_0006);
    chk("mis_state2", 32'(State), 32'd2);
    chk("mis_valid", 32'(InstrValid), 32'd0);
    chk("mis_addr", MemAddress, 32'h6);
    Start = 1'b1; Redirect = 1'b1; Halt = 1'b1; RedirectTarget = 32'h0040_0000;
    step();
    Start = 1'b0; Redirect = 1'b0; Halt = 1'b0;
    step();
    chk("sticky_state", 32'(State), 32'd2);
    chk("sticky_fault", 32'(Fault), 32'd1);
    chk("sticky_faultpc", FaultPC, 32'h0040_0006);
    chk("sticky_addr", MemAddress, 32'h6);
    chk_slot("sticky", 1'b0, 32'h0040_0010, 32'hA000_0004);
    // full window then out-of-range fault
    reset = 1'b0;
    step();
    chk_reset("reset2");
    reset = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    n_valid = 0;
    last_pc = '0;
    for (int i = 0; i < 40 && !Fault; i++) begin
      step();
      if (InstrValid) begin
        chk("win_pc", InstrPC, 32'h0040_0000 + 32'(n_valid) * 4);
        chk("win_instr", Instruction, rom[n_valid[4:0]]);
        last_pc = InstrPC;
        n_valid++;
      end
    end
    chk("win_count", 32'(n_valid), 32'd32);
    chk("win_last", last_pc, 32'h0040_007C);
    chk("win_fault", 32'(Fault), 32'd1);
    chk("win_faultpc", FaultPC, 32'h0040_0080);
    chk("win_state", 32'(State), 32'd2);
    chk("win_valid", 32'(InstrValid), 32'd0);
    // reset mid-RUN with a pending instruction
    reset = 1'b0;
    step();
    reset = 1'b1; Start = 1'b1; InstrReady = 1'b0;
    step();
    Start = 1'b0;
    step();
    chk_slot("pend", 1'b1, 32'h0040_0000, 32'h2008_0005);
    reset = 1'b0;
    step();
    chk_reset("reset3");
    reset = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0; InstrReady = 1'b1;
    step();
    chk_slot("restart", 1'b1, 32'h0040_0000, 32'h2008_0005);
    // halt with a pending instruction, which drains in IDLE
    InstrReady = 1'b0; Halt = 1'b1;
    step();
    Halt = 1'b0;
    chk("halt_state", 32'(State), 32'd0);
    chk("halt_valid", 32'(InstrValid), 32'd1);
    chk("halt_addr", MemAddress, 32'h4);
    InstrReady = 1'b1;
    step();
    chk("drain_valid", 32'(InstrValid), 32'd0);
    chk("drain_state", 32'(State), 32'd0);
    chk("drain_addr", MemAddress, 32'h4);
    // redirect in IDLE sets the start address; Start then fetches from it
    Redirect = 1'b1; RedirectTarget = 32'h0040_0020; Start = 1'b1;
    step();
    Redirect = 1'b0; Start = 1'b0;
    chk("rs_state", 32'(State), 32'd1);
    chk("rs_addr", MemAddress, 32'h20);
    step();
    chk_slot("rs_tgt", 1'b1, 32'h0040_0020, 32'hA000_0008);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
